// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: funct3 codes, FSM states
// and the access-size helper used by the legality check.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  // Bytes touched by an access; 0 marks an unsupported code.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = 3'd1;
      F3_H, F3_HU: size_of = 3'd2;
      F3_W:        size_of = 3'd4;
      default:     size_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin picker. rr_last remembers the most recent winner so a
// tie goes to the other port; it only moves when advance qualifies a grant.
module dmem_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic rr_last_q, rr_last_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (advance && (gnt != 2'b00)) rr_last_d = gnt[1];
  end

  // Starting at 1 lets port 0 win the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) rr_last_q <= 1'b1;
    else       rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the load/store unit (port 0) and the debug/DMA loader (port 1) onto
// the data memory, one transaction per IDLE->ACCESS->RESP pass, rejecting illegal accesses.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [2:0]    p0_funct3,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [2:0]    p1_funct3,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic          p1_err,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_rw,
  output logic [2:0]    mem_funct3,
  input  logic [31:0]   mem_rdata
);

  arb_state_t    state_q, state_d;
  logic          idle;
  logic [1:0]    arb_gnt;
  logic          granted;

  logic          sel;
  logic          sel_we;
  logic [2:0]    sel_f3;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic          f3_ok, align_ok, range_ok, sel_legal;
  logic [AW:0]   last_byte;

  logic          port_q;
  logic          we_q;
  logic [2:0]    funct3_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          legal_q;
  logic [31:0]   resp_rdata;

  assign idle    = (state_q == IDLE);
  assign granted = idle && (arb_gnt != 2'b00);

  dmem_rr_arb u_rr_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({p1_req, p0_req} & {2{idle}}),
    .advance (idle),
    .gnt     (arb_gnt)
  );

  assign sel       = arb_gnt[1];
  assign sel_we    = sel ? p1_we     : p0_we;
  assign sel_f3    = sel ? p1_funct3 : p0_funct3;
  assign sel_addr  = sel ? p1_addr   : p0_addr;
  assign sel_wdata = sel ? p1_wdata  : p0_wdata;

  always_comb begin
    f3_ok = 1'b0;
    case (sel_f3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = ~sel_we;
      default:          f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    align_ok = 1'b1;
    case (sel_f3)
      F3_H, F3_HU: align_ok = ~sel_addr[0];
      F3_W:        align_ok = (sel_addr[1:0] == 2'b00);
      default:     align_ok = 1'b1;
    endcase
  end

  // One extra bit keeps addresses near the top of the space from wrapping into range.
  assign last_byte = {1'b0, sel_addr} + (AW+1)'(size_of(sel_f3)) - (AW+1)'(1);
  assign range_ok  = (last_byte <= (AW+1)'(DEPTH - 1));
  assign sel_legal = f3_ok && align_ok && range_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      legal_q  <= 1'b0;
    end else if (granted) begin
      port_q   <= sel;
      we_q     <= sel_we;
      funct3_q <= sel_f3;
      addr_q   <= sel_addr;
      wdata_q  <= sel_wdata;
      legal_q  <= sel_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (granted) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p0_gnt     = arb_gnt[0];
    p1_gnt     = arb_gnt[1];
    p0_rvalid  = 1'b0;
    p0_rdata   = 32'h0;
    p0_err     = 1'b0;
    p1_rvalid  = 1'b0;
    p1_rdata   = 32'h0;
    p1_err     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_rw     = 1'b0;
    mem_funct3 = 3'b000;
    resp_rdata = 32'h0;
    case (state_q)
      ACCESS: begin
        // Rejected accesses leave every memory pin at zero so nothing can be written.
        if (legal_q) begin
          mem_addr   = 32'(addr_q);
          mem_wdata  = wdata_q;
          mem_funct3 = funct3_q;
          mem_rw     = we_q;
        end
      end
      RESP: begin
        resp_rdata = (legal_q && !we_q) ? mem_rdata : 32'h0;
        if (port_q) begin
          p1_rvalid = 1'b1;
          p1_err    = ~legal_q;
          p1_rdata  = resp_rdata;
        end else begin
          p0_rvalid = 1'b1;
          p0_err    = ~legal_q;
          p0_rdata  = resp_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a byte-array memory drives the mem pins, and a
// transaction-level reference model predicts grants, memory strobes and responses.
module tb_dmem_port_arbiter;

  localparam int DEPTH = 1024;
  localparam int AW    = 32;

  logic          clk;
  logic          reset;
  logic          p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
  logic [2:0]    p0_funct3;
  logic [AW-1:0] p0_addr;
  logic [31:0]   p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [2:0]    p1_funct3;
  logic [AW-1:0] p1_addr;
  logic [31:0]   p1_wdata, p1_rdata;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic          mem_rw;
  logic [2:0]    mem_funct3;

  dmem_port_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_funct3(p1_funct3), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sign/zero extension as the memory performs it.
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // ---------------- memory environment ----------------
  logic [7:0]  env_mem [DEPTH];
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] env_rdata;
  assign mem_rdata = env_rdata;

  always @(posedge clk) begin
    int a;
    logic [31:0] raw;
    a = int'(mem_addr[9:0]);
    raw = {env_mem[(a+3)&1023], env_mem[(a+2)&1023], env_mem[(a+1)&1023], env_mem[a]};
    env_rdata <= extend(raw, mem_funct3);
    if (mem_rw === 1'b1)
      for (int k = 0; k < nbytes(mem_funct3); k++)
        env_mem[(a+k)&1023] <= mem_wdata[8*k +: 8];
  end

  // ---------------- reference model ----------------
  function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    longint last_b;
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        return 1'b0;
    endcase
    if (we && f3 > 3'b010) return 1'b0;
    if ((addr % sz) != 0) return 1'b0;
    last_b = longint'({32'h0, addr}) + sz - 1;
    return last_b <= DEPTH - 1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
    int a;
    a = int'(addr[9:0]);
    return extend({ref_mem[(a+3)&1023], ref_mem[(a+2)&1023], ref_mem[(a+1)&1023], ref_mem[a]}, f3);
  endfunction

  bit          m_pend = 0;
  bit          m_last = 1;
  int          m_cyc  = 0;
  int          m_gcyc = 0;
  bit          m_port, m_we, m_legal;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_wdata;

  always @(negedge clk) begin
    logic [1:0]  eg, ev;
    int          ph;
    logic [31:0] exp_rd;
    eg = 2'b00;
    ev = 2'b00;
    ph = m_pend ? (m_cyc - m_gcyc) : 0;
    if (!m_pend) begin
      if (p0_req && p1_req) eg = m_last ? 2'b01 : 2'b10;
      else                  eg = {p1_req, p0_req};
    end
    check_eq("gnt", {30'h0, p1_gnt, p0_gnt}, {30'h0, eg});
    check_eq("mem_rw", {31'h0, mem_rw}, {31'h0, (m_pend && ph == 1 && m_legal && m_we)});
    if (m_pend && ph == 1) begin
      if (m_legal) begin
        check_eq("mem_addr", mem_addr, m_addr);
        check_eq("mem_funct3", {29'h0, mem_funct3}, {29'h0, m_f3});
        if (m_we) begin
          check_eq("mem_wdata", mem_wdata, m_wdata);
          for (int k = 0; k < nbytes(m_f3); k++)
            ref_mem[(int'(m_addr[9:0]) + k) & 1023] = m_wdata[8*k +: 8];
        end
      end else begin
        check_eq("mem_addr_rej", mem_addr, 32'h0);
      end
    end
    if (m_pend && ph == 2) ev = m_port ? 2'b10 : 2'b01;
    check_eq("rvalid", {30'h0, p1_rvalid, p0_rvalid}, {30'h0, ev});
    if (m_pend && ph == 2) begin
      exp_rd = (m_legal && !m_we) ? ref_load(m_addr, m_f3) : 32'h0;
      check_eq("err",   {31'h0, (m_port ? p1_err : p0_err)}, {31'h0, !m_legal});
      check_eq("rdata", m_port ? p1_rdata : p0_rdata, exp_rd);
      m_pend = 0;
    end
    if (reset) begin
      m_pend = 0;
      m_last = 1;
    end else if (eg != 2'b00) begin
      m_port  = eg[1];
      m_we    = m_port ? p1_we     : p0_we;
      m_f3    = m_port ? p1_funct3 : p0_funct3;
      m_addr  = m_port ? p1_addr   : p0_addr;
      m_wdata = m_port ? p1_wdata  : p0_wdata;
      m_legal = ref_legal(m_we, m_f3, m_addr);
      m_pend  = 1;
      m_gcyc  = m_cyc;
      m_last  = m_port;
    end
    m_cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int p, input bit req, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_funct3 = f3; p0_addr = addr; p0_wdata = wd;
    end else begin
      p1_req = req; p1_we = we; p1_funct3 = f3; p1_addr = addr; p1_wdata = wd;
    end
  endtask

  task automatic issue(input int p, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit exp_err, input logic [31:0] exp_rd,
                       input string tag);
    bit got;
    @(posedge clk); #1;
    drive(p, 1'b1, we, f3, addr, wd);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? p0_gnt : p1_gnt;
    end
    check_eq({tag, "_gnt"}, {31'h0, got}, 32'h1);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, "_rvalid"}, {31'h0, (p == 0) ? p0_rvalid : p1_rvalid}, 32'h1);
    check_eq({tag, "_err"},    {31'h0, (p == 0) ? p0_err : p1_err}, {31'h0, exp_err});
    check_eq({tag, "_rdata"},  (p == 0) ? p0_rdata : p1_rdata, exp_rd);
    $display("txn %s: port=%0d we=%0d f3=%0d addr=0x%08h", tag, p, we, f3, addr);
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int          g_port[$];
  int          g_off[$];
  bit          granted [2];
  logic [2:0]  f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110};

  initial begin
    int nd;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rvalid", {30'h0, p1_rvalid, p0_rvalid}, 32'h0);
    check_eq("rst_mem_rw", {31'h0, mem_rw}, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_rdata", p0_rdata | p1_rdata, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: word store then load back
    issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0, "t1_sw");
    issue(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, "t1_lw");
    // 2: byte store, signed and unsigned byte loads
    issue(1, 1, 3'b000, 32'h23, 32'h80, 0, 32'h0, "t2_sb");
    issue(1, 0, 3'b000, 32'h23, 32'h0, 0, 32'hFFFFFF80, "t2_lb");
    issue(1, 0, 3'b100, 32'h23, 32'h0, 0, 32'h00000080, "t2_lbu");
    // 3: both ports held for 12 cycles alternate from a fresh reset
    pulse_reset(2);
    drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 3'b010, 32'h3FC, 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (p0_gnt) begin g_port.push_back(0); g_off.push_back(i); end
      if (p1_gnt) begin g_port.push_back(1); g_off.push_back(i); end
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check_eq("t3_grants", g_port.size(), 4);
    for (int i = 0; i < g_port.size() && i < 4; i++) begin
      check_eq("t3_port", g_port[i], i % 2);
      check_eq("t3_cycle", g_off[i], 3 * i);
    end
    repeat (3) @(posedge clk);
    // 4: rejected accesses
    issue(0, 0, 3'b010, 32'h002, 32'h0, 1, 32'h0, "t4_lw_mis");
    issue(0, 0, 3'b001, 32'h101, 32'h0, 1, 32'h0, "t4_lh_mis");
    issue(1, 1, 3'b010, 32'h3FE, 32'h55AA55AA, 1, 32'h0, "t4_sw_oor");
    issue(0, 0, 3'b011, 32'h0, 32'h0, 1, 32'h0, "t4_bad_f3");
    // 5: top of memory
    issue(1, 1, 3'b010, 32'h3FC, 32'hCAFEF00D, 0, 32'h0, "t5_sw_top");
    issue(1, 0, 3'b010, 32'h3FC, 32'h0, 0, 32'hCAFEF00D, "t5_lw_top");
    issue(1, 0, 3'b010, 32'hFFFFFFFC, 32'h0, 1, 32'h0, "t5_lw_wrap");
    // 6: reset while a store is in ACCESS
    issue(0, 1, 3'b010, 32'h40, 32'hA5A5A5A5, 0, 32'h0, "t6_pre");
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 3'b010, 32'h40, 32'h12345678);
    for (int i = 0; i < 20 && !p0_gnt; i++) @(negedge clk);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t6_rvalid_rst", {31'h0, p0_rvalid}, 32'h0);
    check_eq("t6_mem_rw_rst", {31'h0, mem_rw}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("t6_rvalid_after", {31'h0, p0_rvalid}, 32'h0);
    issue(0, 0, 3'b010, 32'h40, 32'h0, 0, 32'h12345678, "t6_lw");

    // randomized traffic on both ports
    granted[0] = 1; granted[1] = 1;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < 2; p++) begin
        if (granted[p] || ($urandom_range(0, 7) == 0)) begin
          logic [2:0]  f3;
          logic [31:0] a;
          int r;
          f3 = f3_tab[$urandom_range(0, 7)];
          r  = $urandom_range(0, 9);
          if (r < 7)      a = $urandom_range(0, DEPTH - 1);
          else if (r < 9) a = $urandom_range(DEPTH - 8, DEPTH + 7);
          else            a = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
          if ($urandom_range(0, 1) == 1) a = a & ~32'(nbytes(f3) - 1);
          drive(p, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, f3, a, $urandom);
        end
      end
      @(negedge clk);
      granted[0] = p0_gnt;
      granted[1] = p1_gnt;
      if (p0_gnt || p1_gnt)
        $display("txn rnd: cycle=%0d gnt=%0d%0d reset=%0d", i, p1_gnt, p0_gnt, reset);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (5) @(posedge clk);

    nd = 0;
    for (int i = 0; i < DEPTH; i++) if (env_mem[i] !== ref_mem[i]) nd++;
    check_eq("mem_image", nd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
